// File: rtl/axi_ar_decoder.sv
// Per-master AR decoder: matches a latched read address against the region rules and either
// forwards it with a one-hot destination or answers locally with a DECERR read burst.
module axi_ar_decoder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned N_REGION    = 4,
  parameter int unsigned N_INIT_PORT = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  ar_valid_i,
  output logic                                                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]                                 ar_addr_i,
  input  logic [ID_WIDTH-1:0]                                   ar_id_i,
  input  logic [7:0]                                            ar_len_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                  valid_rule_i,
  input  logic [N_INIT_PORT-1:0]                                connectivity_i,
  output logic                                                  req_valid_o,
  input  logic                                                  req_ready_i,
  output logic [N_INIT_PORT-1:0]                                req_dest_o,
  output logic [ADDR_WIDTH-1:0]                                 req_addr_o,
  output logic [ID_WIDTH-1:0]                                   req_id_o,
  output logic [7:0]                                            req_len_o,
  output logic                                                  err_rvalid_o,
  input  logic                                                  err_rready_i,
  output logic [ID_WIDTH-1:0]                                   err_rid_o,
  output logic [1:0]                                            err_rresp_o,
  output logic                                                  err_rlast_o,
  output logic [ADDR_WIDTH-1:0]                                 err_rdata_o
);

  typedef enum logic [1:0] {StIdle, StDecode, StFwd, StErr} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [N_INIT_PORT-1:0]  dest_q, dest_d;
  logic [N_INIT_PORT-1:0]  hit;
  logic [N_INIT_PORT-1:0]  winner;
  logic                    fwd_ok;

  // A rule with START > END can never satisfy both bounds, so it needs no special case.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(N_INIT_PORT); i++) begin
      for (int r = 0; r < int'(N_REGION); r++) begin
        if (valid_rule_i[r][i] && (addr_q >= START_ADDR_i[r][i]) &&
            (addr_q <= END_ADDR_i[r][i])) begin
          hit[i] = 1'b1;
        end
      end
    end
  end

  // Walk downwards so the lowest hitting index is written last and wins.
  always_comb begin
    winner = '0;
    for (int i = int'(N_INIT_PORT) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end

  assign fwd_ok = |(winner & connectivity_i);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    unique case (state_q)
      StIdle: begin
        if (ar_valid_i && ar_ready_o) begin
          addr_d  = ar_addr_i;
          id_d    = ar_id_i;
          len_d   = ar_len_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        dest_d  = winner;
        cnt_d   = len_q;
        state_d = fwd_ok ? StFwd : StErr;
      end
      StFwd: begin
        if (req_ready_i) state_d = StIdle;
      end
      StErr: begin
        if (err_rready_i) begin
          if (cnt_q == 8'd0) state_d = StIdle;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  assign ar_ready_o   = (state_q == StIdle) && !rst;
  assign req_valid_o  = (state_q == StFwd);
  assign req_dest_o   = dest_q;
  assign req_addr_o   = addr_q;
  assign req_id_o     = id_q;
  assign req_len_o    = len_q;
  assign err_rvalid_o = (state_q == StErr);
  assign err_rlast_o  = (state_q == StErr) && (cnt_q == 8'd0);
  assign err_rid_o    = id_q;
  assign err_rresp_o  = 2'b11;
  assign err_rdata_o  = '0;

endmodule

// File: tb/tb_axi_ar_decoder.sv
// Directed bench for axi_ar_decoder: a vector table of single transactions plus hand-written
// sequences for ready toggling, 256-beat bursts, rule changes in flight and mid-burst reset.
module tb_axi_ar_decoder;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [31:0]            ar_addr;
  logic [3:0]             ar_id;
  logic [7:0]             ar_len;
  logic [3:0][3:0][31:0]  start_addr;
  logic [3:0][3:0][31:0]  end_addr;
  logic [3:0][3:0]        valid_rule;
  logic [3:0]             conn;
  logic                   req_valid;
  logic                   req_ready;
  logic [3:0]             req_dest;
  logic [31:0]            req_addr;
  logic [3:0]             req_id;
  logic [7:0]             req_len;
  logic                   err_rvalid;
  logic                   err_rready;
  logic [3:0]             err_rid;
  logic [1:0]             err_rresp;
  logic                   err_rlast;
  logic [31:0]            err_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_ar_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .ar_valid_i     (ar_valid),
    .ar_ready_o     (ar_ready),
    .ar_addr_i      (ar_addr),
    .ar_id_i        (ar_id),
    .ar_len_i       (ar_len),
    .START_ADDR_i   (start_addr),
    .END_ADDR_i     (end_addr),
    .valid_rule_i   (valid_rule),
    .connectivity_i (conn),
    .req_valid_o    (req_valid),
    .req_ready_i    (req_ready),
    .req_dest_o     (req_dest),
    .req_addr_o     (req_addr),
    .req_id_o       (req_id),
    .req_len_o      (req_len),
    .err_rvalid_o   (err_rvalid),
    .err_rready_i   (err_rready),
    .err_rid_o      (err_rid),
    .err_rresp_o    (err_rresp),
    .err_rlast_o    (err_rlast),
    .err_rdata_o    (err_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [3:0]  conn;
    logic        fwd;
    logic [3:0]  dest;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake at edge k, check DECODE in k+1, return positioned in cycle k+2.
  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    chk("ar_ready_idle", {31'd0, ar_ready}, 32'd1);
    ar_valid = 1'b1;
    ar_addr  = a;
    ar_id    = id;
    ar_len   = len;
    tick();
    ar_valid = 1'b0;
    chk("ar_ready_decode", {31'd0, ar_ready}, 32'd0);
    chk("no_valid_decode", {30'd0, req_valid, err_rvalid}, 32'd0);
    tick();
  endtask

  // With err_rready high, consume a burst and return the number of beats seen.
  task automatic drain_err(input logic [7:0] len, input logic [3:0] id, output int beats);
    logic last;
    beats = 0;
    for (int b = 0; b < 300; b++) begin
      if (!err_rvalid) break;
      if (err_rlast !== (beats == int'(len))) begin
        chk("rlast_pos", {31'd0, err_rlast}, {31'd0, beats == int'(len)});
      end
      if (err_rid !== id) chk("err_rid", {28'd0, err_rid}, {28'd0, id});
      if (req_valid) chk("exclusive_valid", {31'd0, req_valid}, 32'd0);
      last = err_rlast;
      beats++;
      tick();
      if (last) break;
    end
  endtask

  initial begin
    int beats;
    vecs[0]  = '{32'h1000_0000, 4'd3,  8'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[1]  = '{32'h1FFF_FFFF, 4'd3,  8'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[2]  = '{32'h2000_0000, 4'd1,  8'd1, 4'b1111, 1'b0, 4'b0000};
    vecs[3]  = '{32'h0FFF_FFFF, 4'd2,  8'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[4]  = '{32'h0000_2000, 4'd6,  8'd2, 4'b1111, 1'b1, 4'b0010};
    vecs[5]  = '{32'h0000_2000, 4'd7,  8'd1, 4'b1101, 1'b0, 4'b0000};
    vecs[6]  = '{32'h0000_1000, 4'd8,  8'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[7]  = '{32'h9800_0000, 4'd9,  8'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[8]  = '{32'h5000_0000, 4'd10, 8'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[9]  = '{32'h0000_1000, 4'd11, 8'd2, 4'b0111, 1'b0, 4'b0000};
    vecs[10] = '{32'h0000_2FFF, 4'd12, 8'd5, 4'b1111, 1'b1, 4'b0010};
    vecs[11] = '{32'h0000_3000, 4'd13, 8'd2, 4'b1111, 1'b0, 4'b0000};

    start_addr = '0;
    end_addr   = '0;
    valid_rule = '0;
    start_addr[0][2] = 32'h1000_0000; end_addr[0][2] = 32'h1FFF_FFFF; valid_rule[0][2] = 1'b1;
    start_addr[1][3] = 32'h0000_1000; end_addr[1][3] = 32'h0000_2FFF; valid_rule[1][3] = 1'b1;
    start_addr[0][1] = 32'h0000_2000; end_addr[0][1] = 32'h0000_2FFF; valid_rule[0][1] = 1'b1;
    start_addr[2][0] = 32'hA000_0000; end_addr[2][0] = 32'h9000_0000; valid_rule[2][0] = 1'b1;
    start_addr[3][0] = 32'h5000_0000; end_addr[3][0] = 32'h5FFF_FFFF; valid_rule[3][0] = 1'b0;

    rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0;
    conn = 4'b1111; req_ready = 1'b0; err_rready = 1'b1;

    tick();
    tick();
    chk("rst_ar_ready", {31'd0, ar_ready}, 32'd0);
    chk("rst_valids", {29'd0, req_valid, err_rvalid, err_rlast}, 32'd0);
    chk("rst_dest", {28'd0, req_dest}, 32'd0);
    chk("rst_fields", {req_addr | {20'd0, req_id, req_len}}, 32'd0);
    chk("rresp", {30'd0, err_rresp}, 32'd3);
    chk("rdata", err_rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valids", {29'd0, req_valid, err_rvalid, err_rlast}, 32'd0);

    for (int v = 0; v < 12; v++) begin
      conn = vecs[v].conn;
      ar_send(vecs[v].addr, vecs[v].id, vecs[v].len);
      if (vecs[v].fwd) begin
        chk($sformatf("v%0d_req_valid", v), {31'd0, req_valid}, 32'd1);
        chk($sformatf("v%0d_err_rvalid", v), {31'd0, err_rvalid}, 32'd0);
        chk($sformatf("v%0d_dest", v), {28'd0, req_dest}, {28'd0, vecs[v].dest});
        chk($sformatf("v%0d_addr", v), req_addr, vecs[v].addr);
        chk($sformatf("v%0d_id_len", v), {20'd0, req_id, req_len},
            {20'd0, vecs[v].id, vecs[v].len});
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
      end else begin
        chk($sformatf("v%0d_err_first", v), {30'd0, err_rvalid, req_valid}, 32'd2);
        chk($sformatf("v%0d_rresp", v), {30'd0, err_rresp}, 32'd3);
        drain_err(vecs[v].len, vecs[v].id, beats);
        chk($sformatf("v%0d_beats", v), beats, int'(vecs[v].len) + 1);
      end
      chk($sformatf("v%0d_back_idle", v), {29'd0, ar_ready, req_valid, err_rvalid}, 32'd4);
    end

    // Miss with len 3 and err_rready toggled: outputs hold while stalled.
    conn = 4'b1111;
    err_rready = 1'b0;
    ar_send(32'h8000_0000, 4'd5, 8'd3);
    beats = 0;
    for (int b = 0; b < 4; b++) begin
      chk("tog_rvalid", {31'd0, err_rvalid}, 32'd1);
      chk("tog_rlast", {31'd0, err_rlast}, {31'd0, b == 3});
      tick();
      chk("tog_hold_rvalid", {31'd0, err_rvalid}, 32'd1);
      chk("tog_hold_rlast", {31'd0, err_rlast}, {31'd0, b == 3});
      chk("tog_rid", {28'd0, err_rid}, 32'd5);
      err_rready = 1'b1;
      tick();
      err_rready = 1'b0;
      beats++;
    end
    chk("tog_done", {29'd0, ar_ready, req_valid, err_rvalid}, 32'd4);
    err_rready = 1'b1;

    // 256-beat burst: counter must not wrap before rlast.
    ar_send(32'h8000_0000, 4'd4, 8'd255);
    drain_err(8'd255, 4'd4, beats);
    chk("len255_beats", beats, 256);
    chk("len255_idle", {29'd0, ar_ready, req_valid, err_rvalid}, 32'd4);

    // Rules changed while a forward is stalled must not move the destination.
    ar_send(32'h1000_0000, 4'd3, 8'd0);
    chk("hold_fwd_valid", {31'd0, req_valid}, 32'd1);
    start_addr[0][2] = 32'hF000_0000;
    valid_rule[1][2] = 1'b1;
    conn = 4'b0000;
    tick();
    tick();
    chk("hold_fwd_valid2", {31'd0, req_valid}, 32'd1);
    chk("hold_fwd_dest", {28'd0, req_dest}, 32'h4);
    chk("hold_fwd_addr", req_addr, 32'h1000_0000);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    start_addr[0][2] = 32'h1000_0000;
    valid_rule[1][2] = 1'b0;
    conn = 4'b1111;
    chk("hold_fwd_done", {29'd0, ar_ready, req_valid, err_rvalid}, 32'd4);

    // Reset during beat 2 of an error burst abandons it.
    ar_send(32'h8000_0000, 4'd5, 8'd3);
    tick();
    chk("rst_mid_beat2", {31'd0, err_rvalid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_rvalid", {30'd0, err_rvalid, err_rlast}, 32'd0);
    chk("rst_mid_ar_ready", {31'd0, ar_ready}, 32'd0);
    tick();
    chk("rst_mid_ar_ready2", {31'd0, ar_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_back", {31'd0, ar_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_mid_no_stale", {29'd0, ar_ready, req_valid, err_rvalid}, 32'd4);
    end
    chk("rst_mid_fields", {20'd0, req_id, req_len}, 32'd0);

    // One more forward after reset to show the decoder recovered.
    ar_send(32'h0000_2000, 4'd6, 8'd1);
    chk("recover_dest", {29'd0, req_valid, req_dest[1:0]}, 32'h6);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_ar_decoder.md
# axi_ar_decoder

Per-master read-address decoder for the AXI node. Accepts AR requests from one incoming master port and matches each address against the region rules held by the node configuration register file (START/END address, valid-rule bits, connectivity row). It forwards a matching request, tagged with a one-hot destination, to the node's request arbitration. A miss or a disallowed route is answered locally with a DECERR read burst of the requested length.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width; equals the configuration register data width
- ID_WIDTH, 4, AR/R ID width
- N_REGION, 4, rule regions per destination
- N_INIT_PORT, 4, number of destination (slave-side) ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ar_valid_i  in  1  incoming AR valid
- ar_ready_o  out  1  incoming AR ready
- ar_addr_i  in  ADDR_WIDTH  AR address
- ar_id_i  in  ID_WIDTH  AR ID
- ar_len_i  in  8  AR burst length minus one
- START_ADDR_i  in  N_REGION x N_INIT_PORT x ADDR_WIDTH  inclusive range start
- END_ADDR_i  in  N_REGION x N_INIT_PORT x ADDR_WIDTH  inclusive range end
- valid_rule_i  in  N_REGION x N_INIT_PORT  rule enable
- connectivity_i  in  N_INIT_PORT  connectivity row for this master; bit i=1 allows destination i
- req_valid_o  out  1  forwarded request valid
- req_ready_i  in  1  forwarded request ready
- req_dest_o  out  N_INIT_PORT  one-hot destination
- req_addr_o / req_id_o / req_len_o  out  ADDR_WIDTH / ID_WIDTH / 8  latched AR fields
- err_rvalid_o  out  1  error R beat valid
- err_rready_i  in  1  error R beat ready
- err_rid_o  out  ID_WIDTH  latched ID
- err_rresp_o  out  2  constant 2'b11 (DECERR)
- err_rlast_o  out  1  last error beat
- err_rdata_o  out  ADDR_WIDTH  constant zero

## Operation
- State machine states: IDLE, DECODE, FWD, ERR.
- IDLE
  - ar_ready_o = 1 when rst = 0.
  - On ar_valid_i & ar_ready_o, latch addr/id/len and go to DECODE.
- DECODE (one cycle)
  - Rule r,i hits when valid_rule_i[r][i] & (addr >= START[r][i]) & (addr <= END[r][i]). Compare unsigned at full ADDR_WIDTH.
  - hit[i] = OR over r of the rule hits.
  - A rule with START > END never hits.
  - If several i hit, the lowest index i wins.
  - Register req_dest_o as the one-hot winning i.
  - If a winner exists and connectivity_i[winner] = 1, go to FWD.
  - If there is no hit, or the winner's connectivity bit is 0, go to ERR. The connectivity row does not steer the decode to another hit.
  - Rules and connectivity are sampled only in this cycle. Later changes do not affect the transaction in flight.
- FWD
  - req_valid_o = 1; addr/id/len/dest held stable.
  - On req_ready_i, go to IDLE.
- ERR
  - Load the 8-bit beat counter with len on entry.
  - err_rvalid_o = 1. err_rlast_o = 1 when the counter is 0.
  - Each err_rready_i handshake decrements the counter.
  - A handshake with err_rlast_o = 1 returns to IDLE.
  - len = 255 gives 256 beats; the counter must not wrap before rlast.
- req_valid_o and err_rvalid_o are never high together. ar_ready_o is 0 outside IDLE.

## Timing
- Reset: synchronous. While rst = 1 and in the cycle after it falls:
  - state = IDLE
  - ar_ready_o = 0 while rst = 1
  - req_valid_o = 0, err_rvalid_o = 0, err_rlast_o = 0
  - req_dest_o = 0, counter = 0, latched fields = 0
- Reset mid-operation: abandons the transaction; no further beat or request is issued.
- Latency: AR handshake at edge k → DECODE in cycle k+1 → req_valid_o or the first err_rvalid_o high in cycle k+2.
- Minimum spacing: 3 cycles per transaction (handshake, DECODE, one-cycle FWD/ERR with ready already high).
- ar_ready_o returns in the cycle after the final req/err handshake.
- Outputs are stable while valid is high and ready is low (AXI valid/ready rules). Valid never drops without a handshake, except on reset.
- err_rresp_o = 2'b11 and err_rdata_o = 0 at all times.

## Test plan
- Rule [0][2] = 0x1000_0000..0x1FFF_FFFF valid, connectivity 4'b1111; AR addr 0x1000_0000 id 3 len 0 → req_valid_o in cycle k+2, req_dest_o 4'b0100, req_id_o 3. Repeat with addr 0x1FFF_FFFF (inclusive END) → same result.
- No rule covers 0x8000_0000; AR len 3 id 5 → exactly 4 err beats, rid 5, rresp 2'b11, rlast only on the 4th; err_rready_i toggled 1/0 to check that outputs hold and the counter decrements only on handshake.
- Overlapping rules: [1][3] and [0][1] both hit 0x2000 → req_dest_o 4'b0010.
- Hit on destination 1 with connectivity 4'b1101 → DECERR burst. With connectivity 4'b1111 the same AR is forwarded.
- len 255 miss → 256 beats, rlast on beat 256 only. START > END rule never hits. START_ADDR_i is changed during FWD: req_dest_o does not change.
- rst asserted during beat 2 of an ERR burst → err_rvalid_o = 0 in the next cycle. ar_ready_o stays 0 while rst = 1, then returns to 1 with no stale beat.
